// File: rtl/tape_pkg.sv
// Shared types and constants for the tape SDRAM read-port arbiter.
// Optional build macro: TAPE_STRICT_PRIORITY_EN (cassette port always wins).
package tape_pkg;

  localparam int unsigned NUM_PORTS = 3;

  localparam int unsigned P_TAPE   = 0;
  localparam int unsigned P_LOADER = 1;
  localparam int unsigned P_CPU    = 2;

  // Latency counter width; covers RD_LAT up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETURN = 2'd3
  } state_e;

  // Next port index in round-robin order, wrapping 2 -> 0.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: first eligible port at or after ptr.
module rr_pick3
  import tape_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [1:0]           ptr_i,
  input  logic [NUM_PORTS-1:0] mask_i,
  output logic [NUM_PORTS-1:0] grant_c_o,
  output logic [1:0]           idx_c_o,
  output logic                 valid_c_o
);

  logic [NUM_PORTS-1:0] elig;
  logic [1:0]           cand;

  // Walk ptr, ptr+1, ptr+2 (mod 3) and grant the first masked-in requester.
  always_comb begin
    elig      = req_i & mask_i;
    cand      = (ptr_i > 2'd2) ? 2'd0 : ptr_i;
    grant_c_o = '0;
    idx_c_o   = '0;
    valid_c_o = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!valid_c_o && elig[cand]) begin
        grant_c_o[cand] = 1'b1;
        idx_c_o         = cand;
        valid_c_o       = 1'b1;
      end
      cand = next_port(cand);
    end
  end

endmodule

// File: rtl/tape_sdram_arbiter.sv
// Arbitrates the byte-wide SDRAM read port between cassette, loader and CPU.
// One read in flight at a time; build with TAPE_STRICT_PRIORITY_EN to make
// the cassette port win unconditionally.
module tape_sdram_arbiter
  import tape_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned AW     = 25
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [AW-1:0]        addr0,
  input  logic [AW-1:0]        addr1,
  input  logic [AW-1:0]        addr2,
  output logic [NUM_PORTS-1:0] ack,
  output logic [7:0]           rdata,
  output logic [NUM_PORTS-1:0] rvalid,
  output logic [AW-1:0]        sdram_addr,
  output logic                 sdram_rd,
  input  logic [7:0]           sdram_data,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           cur_q, cur_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [7:0]           rdata_q, rdata_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 rd_q, rd_d;
  logic                 busy_q, busy_d;

  logic [NUM_PORTS-1:0] pick_mask;
  logic [NUM_PORTS-1:0] pick_grant;
  logic [1:0]           pick_idx;
  logic                 pick_valid;
  logic [AW-1:0]        addr_sel;

`ifdef TAPE_STRICT_PRIORITY_EN
  // Cassette alone is eligible while it requests; otherwise loader and CPU share.
  assign pick_mask = req[P_TAPE] ? 3'b001 : 3'b110;
`else
  assign pick_mask = 3'b111;
`endif

  rr_pick3 u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .mask_i    (pick_mask),
    .grant_c_o (pick_grant),
    .idx_c_o   (pick_idx),
    .valid_c_o (pick_valid)
  );

  // Address of the winning port.
  always_comb begin
    if (pick_idx == 2'(P_TAPE)) begin
      addr_sel = addr0;
    end else if (pick_idx == 2'(P_LOADER)) begin
      addr_sel = addr1;
    end else begin
      addr_sel = addr2;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (pick_valid) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_WAIT;
      ST_WAIT:   if (cnt_q == '0) state_d = ST_RETURN;
      ST_RETURN: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    ack_d    = '0;
    rvalid_d = '0;
    rd_d     = 1'b0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    cur_d    = cur_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    busy_d   = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          ack_d  = pick_grant;
          addr_d = addr_sel;
          cur_d  = pick_idx;
        end
      end
      ST_ISSUE: begin
        rd_d  = 1'b1;
        cnt_d = CNT_W'(RD_LAT - 1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = sdram_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RETURN: begin
        rvalid_d[cur_q] = 1'b1;
`ifdef TAPE_STRICT_PRIORITY_EN
        // Cassette wins do not advance the loader/CPU rotation.
        if (cur_q != 2'(P_TAPE)) begin
          ptr_d = next_port(cur_q);
        end
`else
        ptr_d = next_port(cur_q);
`endif
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath; reset aborts any read in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      cur_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      cur_q    <= cur_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ack        = ack_q;
  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign sdram_addr = addr_q;
  assign sdram_rd   = rd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tape_sdram_arbiter.sv
// Self-checking bench for tape_sdram_arbiter (RD_LAT=2 main instance,
// RD_LAT=1 second instance for the short-latency boundary).
module tb_tape_sdram_arbiter;

  localparam int unsigned AW  = 25;
  localparam int          LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    req = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [2:0]    ack, rvalid;
  logic [7:0]    rdata;
  logic [7:0]    sdram_data = '0;
  logic [AW-1:0] sdram_addr;
  logic          sdram_rd, busy;

  logic [2:0]    req_b = '0;
  logic [AW-1:0] addr_b = '0;
  logic [2:0]    ack_b, rvalid_b;
  logic [7:0]    rdata_b;
  logic [7:0]    data_b = '0;
  logic [AW-1:0] sdram_addr_b;
  logic          sdram_rd_b, busy_b;

  tape_sdram_arbiter #(.RD_LAT(2), .AW(AW)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .ack(ack), .rdata(rdata), .rvalid(rvalid),
    .sdram_addr(sdram_addr), .sdram_rd(sdram_rd),
    .sdram_data(sdram_data), .busy(busy)
  );

  tape_sdram_arbiter #(.RD_LAT(1), .AW(AW)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req_b),
    .addr0(addr_b), .addr1(addr_b), .addr2(addr_b),
    .ack(ack_b), .rdata(rdata_b), .rvalid(rvalid_b),
    .sdram_addr(sdram_addr_b), .sdram_rd(sdram_rd_b),
    .sdram_data(data_b), .busy(busy_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            m_active;
  int            m_t, m_cur, m_ptr;
  logic [7:0]    m_rdata;
  logic [AW-1:0] m_addr;
  logic [2:0]    e_ack, e_rv;
  bit            e_rd;

  function automatic int pick(input logic [2:0] r, input int ptr);
`ifdef TAPE_STRICT_PRIORITY_EN
    if (r[0]) return 0;
    r[0] = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      if (r[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_t = 0; m_cur = 0; m_ptr = 0;
    m_rdata = '0; m_addr = '0;
  endtask

  // One clock edge: t counts edges since the grant edge.
  task automatic model_step(input logic [2:0] r, input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                            input logic [7:0] d);
    int w;
    e_ack = '0; e_rv = '0; e_rd = 0;
    if (!m_active) begin
      if (r != 3'b000) begin
        w = pick(r, m_ptr);
        e_ack = 3'(1 << w);
        m_addr = (w == 0) ? a0 : (w == 1) ? a1 : a2;
        m_cur = w; m_active = 1; m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t == 1) e_rd = 1;
      if (m_t == 1 + LAT) m_rdata = d;
      if (m_t == LAT + 2) begin
        e_rv = 3'(1 << m_cur);
`ifdef TAPE_STRICT_PRIORITY_EN
        if (m_cur != 0) m_ptr = (m_cur + 1) % 3;
`else
        m_ptr = (m_cur + 1) % 3;
`endif
        m_active = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req = '0; req_b = '0;
    #1;
    chk("rst_ack",    32'(ack),        32'(0));
    chk("rst_rvalid", 32'(rvalid),     32'(0));
    chk("rst_rdata",  32'(rdata),      32'(0));
    chk("rst_saddr",  32'(sdram_addr), 32'(0));
    chk("rst_rd",     32'(sdram_rd),   32'(0));
    chk("rst_busy",   32'(busy),       32'(0));
    chk("rst_b_busy", 32'(busy_b),     32'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]    req;
    logic [AW-1:0] a1;
    logic [7:0]    d;
    logic [2:0]    e_ack;
    logic          e_rd;
    logic [2:0]    e_rv;
    logic [7:0]    e_rdata;
    logic          e_busy;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vt[6];

  initial begin
    int            acks[$];
    int            exp_order[9];
    int            cyc, got;
    int            rd_cnt, ack2_cnt, rv0_cnt, ack_cyc;
    logic [2:0]    base;
    logic [7:0]    nd, exp_b;
    bit            seen_rv;

    // single read on port 1, RD_LAT=2
    vt[0] = '{3'b010, AW'(32'h123), 8'h3C, 3'b010, 1'b0, 3'b000, 8'h00, 1'b1, AW'(32'h123)};
    vt[1] = '{3'b000, AW'(32'h7FF), 8'h3C, 3'b000, 1'b1, 3'b000, 8'h00, 1'b1, AW'(32'h123)};
    vt[2] = '{3'b000, AW'(32'h7FF), 8'h3C, 3'b000, 1'b0, 3'b000, 8'h00, 1'b1, AW'(32'h123)};
    vt[3] = '{3'b000, AW'(32'h7FF), 8'hA5, 3'b000, 1'b0, 3'b000, 8'hA5, 1'b1, AW'(32'h123)};
    vt[4] = '{3'b000, AW'(32'h7FF), 8'h3C, 3'b000, 1'b0, 3'b010, 8'hA5, 1'b0, AW'(32'h123)};
    vt[5] = '{3'b000, AW'(32'h7FF), 8'h3C, 3'b000, 1'b0, 3'b000, 8'hA5, 1'b0, AW'(32'h123)};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      req = vt[i].req; addr1 = vt[i].a1; sdram_data = vt[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ack", i),   32'(ack),        32'(vt[i].e_ack));
      chk($sformatf("vec%0d_rd", i),    32'(sdram_rd),   32'(vt[i].e_rd));
      chk($sformatf("vec%0d_rv", i),    32'(rvalid),     32'(vt[i].e_rv));
      chk($sformatf("vec%0d_rdata", i), 32'(rdata),      32'(vt[i].e_rdata));
      chk($sformatf("vec%0d_busy", i),  32'(busy),       32'(vt[i].e_busy));
      chk($sformatf("vec%0d_saddr", i), 32'(sdram_addr), 32'(vt[i].e_addr));
    end

    // round-robin order with all ports requesting, then ports 1/2 only
`ifdef TAPE_STRICT_PRIORITY_EN
    exp_order = '{0, 0, 0, 0, 0, 0, 1, 2, 1};
`else
    exp_order = '{0, 1, 2, 0, 1, 2, 1, 2, 1};
`endif
    do_reset();
    base = 3'b111; req = base;
    cyc = 0;
    while (acks.size() < 9 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (ack != 3'b000) begin
        got = (ack == 3'b001) ? 0 : (ack == 3'b010) ? 1 : (ack == 3'b100) ? 2 : 9;
        acks.push_back(got);
        if (acks.size() == 6) base = 3'b110;
        req = base & ~ack;
      end else begin
        req = base;
      end
    end
    req = '0;
    chk("rr_count", 32'(acks.size()), 32'(9));
    for (int i = 0; i < 9; i++) begin
      got = (i < acks.size()) ? acks[i] : -1;
      chk($sformatf("rr_order%0d", i), 32'(got), 32'(exp_order[i]));
    end

    // reset while waiting on SDRAM data
    do_reset();
    sdram_data = 8'h5A; addr0 = AW'(32'h0ABCDE); addr2 = AW'(32'h155555);
    req = 3'b001;
    @(posedge clk); #1;
    chk("mrst_ack0", 32'(ack), 32'(3'b001));
    req = 3'b000;
    @(posedge clk); #1;
    chk("mrst_rd", 32'(sdram_rd), 32'(1));
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mrst_rd0",    32'(sdram_rd),   32'(0));
    chk("mrst_busy0",  32'(busy),       32'(0));
    chk("mrst_saddr0", 32'(sdram_addr), 32'(0));
    chk("mrst_rdata0", 32'(rdata),      32'(0));
    seen_rv = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rvalid != 3'b000) seen_rv = 1;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rvalid != 3'b000) seen_rv = 1;
    end
    chk("mrst_no_rvalid", 32'(seen_rv), 32'(0));
    req = 3'b100;
    @(posedge clk); #1;
    chk("mrst_ack2",  32'(ack),        32'(3'b100));
    chk("mrst_saddr", 32'(sdram_addr), 32'(32'h155555));
    req = 3'b000;
    cyc = 0;
    while (rvalid == 3'b000 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mrst_rv_lat",  32'(cyc),    32'(LAT + 2));
    chk("mrst_rv_port", 32'(rvalid), 32'(3'b100));
    chk("mrst_rdata",   32'(rdata),  32'(8'h5A));

    // port 2 withdraws its request before the arbiter returns to idle
    do_reset();
    req = 3'b001;
    @(posedge clk); #1;
    chk("wd_ack0", 32'(ack), 32'(3'b001));
    req = 3'b100;
    rd_cnt = 0; ack2_cnt = 0; rv0_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) req = 3'b000;
      if (sdram_rd) rd_cnt++;
      if (ack[2]) ack2_cnt++;
      if (rvalid[0]) rv0_cnt++;
    end
    chk("wd_rd_count",   32'(rd_cnt),   32'(1));
    chk("wd_ack2_count", 32'(ack2_cnt), 32'(0));
    chk("wd_rv0_count",  32'(rv0_cnt),  32'(1));

    // RD_LAT=1 instance with data changing every cycle
    do_reset();
    req_b = 3'b010; addr_b = AW'(32'h42);
    ack_cyc = -1; exp_b = 8'h00; seen_rv = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      nd = 8'(c * 7 + 3);
      if (ack_b != 3'b000) begin
        ack_cyc = c;
        req_b = 3'b000;
        chk("l1_ack", 32'(ack_b), 32'(3'b010));
      end
      if (sdram_rd_b) exp_b = nd;
      if (rvalid_b != 3'b000 && !seen_rv) begin
        seen_rv = 1;
        chk("l1_rv_port", 32'(rvalid_b),    32'(3'b010));
        chk("l1_rdata",   32'(rdata_b),     32'(exp_b));
        chk("l1_rv_lat",  32'(c - ack_cyc), 32'(3));
      end
      data_b = nd;
    end
    chk("l1_seen_rv", 32'(seen_rv), 32'(1));

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      model_step(req, addr0, addr1, addr2, sdram_data);
      #1;
      chk("rnd_ack",   32'(ack),        32'(e_ack));
      chk("rnd_rd",    32'(sdram_rd),   32'(e_rd));
      chk("rnd_rv",    32'(rvalid),     32'(e_rv));
      chk("rnd_rdata", 32'(rdata),      32'(m_rdata));
      chk("rnd_saddr", 32'(sdram_addr), 32'(m_addr));
      chk("rnd_busy",  32'(busy),       32'(m_active));
      for (int p = 0; p < 3; p++) begin
        if (req[p]) begin
          if (ack[p] || $urandom_range(0, 15) == 0) req[p] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[p] = 1'b1;
          if (p == 0) addr0 = AW'($urandom);
          else if (p == 1) addr1 = AW'($urandom);
          else addr2 = AW'($urandom);
        end
      end
      sdram_data = 8'($urandom);
    end
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
